// File: rtl/hud_digit_sequencer_if.sv
// hud_digit_sequencer_if: shared digit glyph ROM port (address out, row data back one cycle later)
interface hud_digit_sequencer_if;
    logic [7:0] glyph_addr;
    logic [7:0] glyph_data;
    modport master (output glyph_addr, input glyph_data);
    modport slave  (input glyph_addr, output glyph_data);
endinterface

// File: rtl/hud_digit_sequencer.sv
// hud_digit_sequencer: game clock/score counters, run state, and HUD digit rendering from a shared glyph ROM
module hud_digit_sequencer #(
    parameter int PIXEL_DISPLAY_BIT = 9,
    parameter int TICK_DIV          = 25000000,
    parameter int TIME_X0           = 176,
    parameter int SCORE_X0          = 450,
    parameter int HUD_Y0            = 460
) (
    input  logic                       clock_25,
    input  logic                       reset,
    input  logic [PIXEL_DISPLAY_BIT:0] X,
    input  logic [PIXEL_DISPLAY_BIT:0] Y,
    input  logic                       start,
    input  logic                       pause,
    input  logic                       game_over,
    input  logic                       score_inc,
    hud_digit_sequencer_if.master      rom,
    output logic                       pixel_out,
    output logic [1:0]                 game_state,
    output logic [15:0]                time_bcd,
    output logic [15:0]                score_bcd
);
    localparam int W  = PIXEL_DISPLAY_BIT + 1;
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, PAUSED = 2'b10, OVER = 2'b11;

    logic [1:0]    state_next;
    logic          end_game, clear, running, tick;
    logic [PW-1:0] prescaler;
    logic          c0, c1, c2, score_carry;
    logic [15:0]   time_next, score_next;
    logic          in_y, in_time, in_score, hit, hit_d1;
    logic [4:0]    dx;
    logic [3:0]    row, digit;
    logic [2:0]    col_d1;

    // next state: game_over outranks start outranks pause; a start that is not overridden clears everything
    always_comb begin
        end_game   = game_over & (game_state == RUN | game_state == PAUSED);
        clear      = start & ~end_game;
        running    = game_state == RUN & ~clear;
        tick       = running & prescaler == PW'(TICK_DIV - 1);
        state_next = end_game ? OVER :
                     start ? RUN :
                     (pause & game_state == RUN) ? PAUSED :
                     (pause & game_state == PAUSED) ? RUN : game_state;
    end

    // mm:ss BCD increment with carries, holding at 99:59
    always_comb begin
        c0        = time_bcd[3:0] == 4'd9;
        c1        = c0 & time_bcd[7:4] == 4'd5;
        c2        = c1 & time_bcd[11:8] == 4'd9;
        time_next = time_bcd == 16'h9959 ? time_bcd : {
                        c2 ? time_bcd[15:12] + 4'd1 : time_bcd[15:12],
                        c1 ? (c2 ? 4'd0 : time_bcd[11:8] + 4'd1) : time_bcd[11:8],
                        c0 ? (c1 ? 4'd0 : time_bcd[7:4] + 4'd1) : time_bcd[7:4],
                        c0 ? 4'd0 : time_bcd[3:0] + 4'd1};
    end

    // 4-digit BCD score increment, holding at 9999
    always_comb begin
        score_next  = score_bcd;
        score_carry = score_bcd != 16'h9999;
        for (int i = 0; i < 4; i++) begin
            score_next[4*i +: 4] = score_carry ? (score_bcd[4*i +: 4] == 4'd9 ? 4'd0 : score_bcd[4*i +: 4] + 4'd1)
                                               : score_bcd[4*i +: 4];
            score_carry = score_carry & score_bcd[4*i +: 4] == 4'd9;
        end
    end

    // state register, prescaler and counters; prescaler is kept across pause so resume keeps the phase
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            game_state <= IDLE;
            prescaler  <= '0;
            time_bcd   <= '0;
            score_bcd  <= '0;
        end else begin
            game_state <= state_next;
            prescaler  <= (clear | tick) ? '0 : running ? prescaler + 1'b1 : prescaler;
            time_bcd   <= clear ? '0 : tick ? time_next : time_bcd;
            score_bcd  <= clear ? '0 : (running & score_inc) ? score_next : score_bcd;
        end
    end

    // field decode; offsets are only formed inside a field so no wrapped difference is used
    always_comb begin
        in_y     = Y >= W'(HUD_Y0) & Y <= W'(HUD_Y0 + 15);
        in_time  = X >= W'(TIME_X0) & X <= W'(TIME_X0 + 31);
        in_score = X >= W'(SCORE_X0) & X <= W'(SCORE_X0 + 31);
        hit      = in_y & (in_time | in_score);
        dx       = in_time ? 5'(X - W'(TIME_X0)) : in_score ? 5'(X - W'(SCORE_X0)) : 5'd0;
        row      = in_y ? 4'(Y - W'(HUD_Y0)) : 4'd0;
        digit    = in_time ? time_bcd[{~dx[4:3], 2'b00} +: 4] : score_bcd[{~dx[4:3], 2'b00} +: 4];
    end

    // stage 0 issues the ROM address (held on non-hit pixels); stage 1 picks the column bit from the returned row
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            rom.glyph_addr <= '0;
            col_d1         <= '0;
            hit_d1         <= 1'b0;
            pixel_out      <= 1'b0;
        end else begin
            if (hit) rom.glyph_addr <= {digit, row};
            col_d1    <= dx[2:0];
            hit_d1    <= hit;
            pixel_out <= hit_d1 & rom.glyph_data[3'd7 - col_d1];
        end
    end
endmodule

// File: doc/hud_digit_sequencer.md
Name: hud_digit_sequencer

Overview:
- Owns the game clock (mm:ss) and score counters and the run/pause/over state.
- Renders the 4 time digits and 4 score digits into the HUD band (Y 460..475), next to the TIME:/SCORE: labels produced by the background block.
- Sequences reads of a shared 1-cycle-latency digit glyph ROM and outputs a registered pixel that the top level ORs with the background datarom.

Parameters:
- PIXEL_DISPLAY_BIT, 9, MSB index of X/Y pixel coordinates.
- TICK_DIV, 25000000, clock_25 cycles per game second.
- TIME_X0, 176, first pixel column of the time digit field.
- SCORE_X0, 450, first pixel column of the score digit field.
- HUD_Y0, 460, first HUD row; the band is 16 rows tall.

Ports:
- clock_25  in  1  pixel clock, 25 MHz.
- reset  in  1  asynchronous, active-low.
- X  in  PIXEL_DISPLAY_BIT+1  current pixel column.
- Y  in  PIXEL_DISPLAY_BIT+1  current pixel row.
- start  in  1  1-cycle pulse: begin or restart game.
- pause  in  1  1-cycle pulse: toggle RUN/PAUSED.
- game_over  in  1  1-cycle pulse: end game.
- score_inc  in  1  1-cycle pulse: add 1 to score.
- glyph_data  in  8  ROM row data, valid 1 cycle after glyph_addr; bit 7 is the leftmost pixel.
- glyph_addr  out  8  {digit[3:0], row[3:0]}.
- pixel_out  out  1  HUD digit pixel.
- game_state  out  2  00 IDLE, 01 RUN, 10 PAUSED, 11 OVER.
- time_bcd  out  16  {m10,m1,s10,s1}.
- score_bcd  out  16  {d3,d2,d1,d0}.

Behaviour:

Reset (async, reset=0):
- All state registers clear: state=IDLE, prescaler=0, time_bcd=0, score_bcd=0.
- Outputs: glyph_addr=0, pixel_out=0, and all pipeline valid flags=0.
- Reset asserted mid-frame or mid-game takes effect immediately. No pulse is remembered across reset.

FSM (evaluated each clock):
- Input priority: game_over > start > pause.
- IDLE: start -> RUN, clearing prescaler, time and score. pause and game_over are ignored.
- RUN: game_over -> OVER; start -> RUN with a full clear (restart); pause -> PAUSED.
- PAUSED: game_over -> OVER; start -> RUN with full clear; pause -> RUN with prescaler preserved.
- OVER: start -> RUN with full clear. All other inputs ignored; counters frozen.

Timer:
- Counts only in RUN. The prescaler counts 0..TICK_DIV-1; the tick occurs on the wrap.
- On a tick, s1 increments as BCD: s1 9->0 carries to s10; s10 5->0 carries to m1; m1 9->0 carries to m10.
- Saturates at 99:59: no further change, no wrap.

Score:
- score_inc is accepted only in RUN, including the same cycle as a tick.
- 4-digit BCD increment; saturates at 9999.
- score_inc in the same cycle as start is dropped, because the clear wins.

Render pipeline:
- Stage 0 (on clock edge):
  - hit when Y in HUD_Y0..HUD_Y0+15 and X is in [TIME_X0, TIME_X0+31] or [SCORE_X0, SCORE_X0+31].
  - cell = (X - field_x0) >> 3; row = Y - HUD_Y0 (4 bits); col = (X - field_x0) & 7.
  - Digit selection: cell 0..3 selects m10, m1, s10, s1 (time) or d3..d0 (score).
  - Register glyph_addr = {digit,row}, col_d1 = col, hit_d1 = hit.
  - On a non-hit pixel, glyph_addr holds its previous value.
- Stage 1: pixel_out <= hit_d1 & glyph_data[7 - col_d1].
- Latency: pixel_out for pixel (X,Y) appears 2 clocks after X,Y are presented. The top level delays background by 1 to align.
- Digits are sampled at stage 0. A counter change mid-line may alter later cells of the same line; this is accepted.
- Subtraction widths: PIXEL_DISPLAY_BIT+1 bits, evaluated only when in range, so no underflow reaches the outputs.

Test Plan:
- Reset/IDLE: hold reset=0 with pulses active -> state=00, time_bcd=0000, score_bcd=0000, pixel_out=0. Release and pulse pause and game_over -> state stays 00.
- Timer carry (TICK_DIV=4): start, then run 4*60 cycles -> time_bcd=0x0100. Force time to 99:59, apply one more tick -> stays 0x9959.
- Pause/priority: start, 2 ticks, pause -> state=10, time frozen at 0x0002. Pulse pause+game_over in the same cycle -> state=11.
- Score: in RUN, 12 score_inc pulses -> score_bcd=0x0012. Preset 0x9999 + 1 pulse -> 0x9999. Pulse while PAUSED -> unchanged. Pulse with start -> 0x0000.
- Render: time=0x0107, Y=465, X=TIME_X0+8*3+2 -> glyph_addr=0x75 next cycle. Drive glyph_data=0x20 -> pixel_out=1 two cycles after the X/Y sample. X=TIME_X0+32 -> pixel_out=0.
- Async reset mid-render: assert reset between stage 0 and stage 1 -> pixel_out=0 immediately, state=IDLE.
